// File: rtl/timer_irq_dev.sv
// ---------------------------------------------------------------------------
// timer_irq_dev -- memory-mapped countdown timer with one interrupt line.
//
// Ports:
//   clk    system clock (same domain as CPU and bridge)
//   reset  asynchronous, active-high reset
//   Addr   register select: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved
//   WE     write strobe, sampled on rising clk
//   Din    write data
//   Dout   combinational read data for the register selected by Addr
//   IRQ    level interrupt request = IM & irq_flag
//
// CTRL[0]=Enable, CTRL[2:1]=Mode (1=auto-reload, anything else one-shot),
// CTRL[3]=IM (1=interrupt unmasked).
// ---------------------------------------------------------------------------
module timer_irq_dev #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;

    logic               enable;
    logic [1:0]         mode;
    logic               irq_mask;

    assign enable   = ctrl_q[0];
    assign mode     = ctrl_q[2:1];
    assign irq_mask = ctrl_q[3];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: FSM first, then bus writes override everything.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // COUNT of 0 or 1 both expire here, so PRESET=0 never wraps.
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (mode == 2'd1) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    // One-shot: flag remains until software rewrites CTRL/PRESET.
                    ctrl_d  = {ctrl_q[3:1], 1'b0};
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A CTRL/PRESET write discards the FSM's update for this edge,
        // COUNT included, and restarts from IDLE.
        if (WE) begin
            case (Addr)
                2'd0: begin
                    ctrl_d     = Din[3:0];
                    preset_d   = preset_q;
                    count_d    = count_q;
                    irq_flag_d = 1'b0;
                    state_d    = ST_IDLE;
                end
                2'd1: begin
                    ctrl_d     = ctrl_q;
                    preset_d   = Din[CNT_W-1:0];
                    count_d    = count_q;
                    irq_flag_d = 1'b0;
                    state_d    = ST_IDLE;
                end
                default: ; // COUNT and reserved are not writable
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and interrupt output
    // -----------------------------------------------------------------------
    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0:    Dout = {28'd0, ctrl_q};
            2'd1:    Dout = 32'(preset_q);
            2'd2:    Dout = 32'(count_q);
            default: Dout = '0;
        endcase
    end

    assign IRQ = irq_mask & irq_flag_q;

endmodule

// File: tb/tb_timer_irq_dev.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_dev -- scoreboard bench for timer_irq_dev.
// The driver applies one bus cycle per clock, steps a behavioural model of
// the timer, and pushes the expected read value / IRQ into a queue.  The
// monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_timer_irq_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    always #5 clk = ~clk;

    timer_irq_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    task automatic m_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_flag   = 1'b0;
        m_phase  = PH_IDLE;
    endtask

    task automatic m_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
        if (we && a == 2'd0) begin
            m_ctrl  = d[3:0];
            m_flag  = 1'b0;
            m_phase = PH_IDLE;
        end else if (we && a == 2'd1) begin
            m_preset = d;
            m_flag   = 1'b0;
            m_phase  = PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (m_ctrl[0]) m_phase = PH_LOAD;
                PH_LOAD: begin
                    m_count = m_preset;
                    m_phase = PH_CNT;
                end
                PH_CNT: begin
                    if (!m_ctrl[0]) m_phase = PH_IDLE;
                    else if (m_count > 1) m_count = m_count - 1;
                    else begin
                        m_count = 0;
                        m_flag  = 1'b1;
                        m_phase = PH_INT;
                    end
                end
                default: begin
                    if (m_ctrl[2:1] == 2'd1) begin
                        m_flag  = 1'b0;
                        m_phase = PH_LOAD;
                    end else begin
                        m_ctrl[0] = 1'b0;
                        m_phase   = PH_IDLE;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] dout;
        logic        irq;
        logic [1:0]  addr;
    } exp_t;
    exp_t sb[$];

    // Monitor: outputs are stable one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (Dout !== e.dout || IRQ !== e.irq) begin
                n_err++;
                $display("FAIL readback addr=%0d got dout=%h irq=%b expected dout=%h irq=%b",
                         e.addr, Dout, IRQ, e.dout, e.irq);
            end
        end
    end

    // One bus cycle: drive at the falling edge, predict the post-edge view.
    task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        WE   = we;
        Addr = a;
        Din  = d;
        m_edge(we, a, d);
        e.dout = m_read(a);
        e.irq  = m_ctrl[3] & m_flag;
        e.addr = a;
        sb.push_back(e);
        $display("cyc we=%b addr=%0d din=%h -> exp dout=%h irq=%b", we, a, d, e.dout, e.irq);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, a, 32'd0);
    endtask

    // Run until the model sits counting at COUNT==v (bounded).
    task automatic run_to_count(input logic [31:0] v);
        int k;
        k = 0;
        while (!(m_phase == PH_CNT && m_count == v) && k < 200) begin
            cyc(1'b0, 2'd2, 32'd0);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL run_to_count timeout got count=%h required %h", m_count, v);
        end
    endtask

    // Asynchronous reset between edges; check outputs with no clock edge.
    task automatic async_reset_check();
        @(posedge clk);
        #2;
        WE    = 1'b0;
        reset = 1'b1;
        m_reset();
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            n_vec++;
            if (Dout !== 32'd0 || IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset addr=%0d got dout=%h irq=%b required dout=0 irq=0",
                         a, Dout, IRQ);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;
        reset = 1'b1;
        m_reset();
        #1;
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            n_vec++;
            if (Dout !== 32'd0 || IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state addr=%0d got dout=%h irq=%b required 0/0", a, Dout, IRQ);
            end
        end
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-count
        cyc(1'b1, 2'd1, 32'd10);
        cyc(1'b1, 2'd0, 32'hB);
        run_to_count(32'd6);
        async_reset_check();
        idle(3, 2'd2);
        idle(1, 2'd0);

        // One-shot
        cyc(1'b1, 2'd1, 32'd5);
        cyc(1'b1, 2'd0, 32'h9);
        idle(8, 2'd2);
        idle(2, 2'd0);
        cyc(1'b1, 2'd0, 32'h8);
        idle(2, 2'd0);

        // Auto-reload
        cyc(1'b1, 2'd1, 32'd3);
        cyc(1'b1, 2'd0, 32'hB);
        idle(16, 2'd2);

        // Masked flag, unmask, then a full-scale PRESET
        cyc(1'b1, 2'd1, 32'd0);
        cyc(1'b1, 2'd0, 32'h1);
        idle(5, 2'd0);
        cyc(1'b1, 2'd0, 32'h9);
        idle(5, 2'd0);
        cyc(1'b1, 2'd1, 32'hFFFF_FFFF);
        cyc(1'b1, 2'd0, 32'h1);
        idle(6, 2'd2);

        // Pause at COUNT=4
        cyc(1'b1, 2'd1, 32'd10);
        cyc(1'b1, 2'd0, 32'h9);
        run_to_count(32'd4);
        cyc(1'b1, 2'd0, 32'h8);
        idle(3, 2'd2);

        // PRESET write colliding with the edge that would enter INT
        cyc(1'b1, 2'd1, 32'd3);
        cyc(1'b1, 2'd0, 32'h9);
        run_to_count(32'd1);
        cyc(1'b1, 2'd1, 32'd7);
        idle(4, 2'd2);
        cyc(1'b1, 2'd2, 32'h1234);
        cyc(1'b1, 2'd3, 32'hFFFF_FFFF);
        idle(2, 2'd3);
        idle(8, 2'd2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cyc(1'b1, 2'd0, $urandom);
            end else if (r < 14) begin
                if ($urandom_range(0, 9) == 0) cyc(1'b1, 2'd1, $urandom);
                else cyc(1'b1, 2'd1, 32'($urandom_range(0, 8)));
            end else if (r < 18) begin
                cyc(1'b1, 2'(2 + $urandom_range(0, 1)), $urandom);
            end else begin
                cyc(1'b0, 2'($urandom_range(0, 3)), $urandom);
            end
            if (i == 300) async_reset_check();
        end

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
